// File: rtl/shift_clock_scheduler_pkg.sv
// Shared types and defaults for the per-bit backscatter shift clock.
// Imported by the scheduler top and its half-period divider.
package shift_clock_scheduler_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [11:0] DEF_HALF    = 12'd49;
    localparam logic [15:0] DEF_BIT_LEN = 16'd399;

endpackage

// File: rtl/shift_clock_scheduler_half_period_divider.sv
// Runtime-limit half-period divider driving the shift clock.
// Clock level is kept across phase resets so bit boundaries stay glitch-free.
module half_period_divider
    import shift_clock_scheduler_pkg::*;
#(
    parameter int CNT_W = 12
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic [CNT_W-1:0] half_lim,
    input  logic             run,
    input  logic             phase_rst,
    output logic             clock_out
);

    logic [CNT_W-1:0] div_cnt;
    logic             hit;

    assign hit = (div_cnt == half_lim);

    // Leaving run parks the output low; a toggle due at a phase reset still fires.
    always_ff @(posedge clock_in) begin
        if (reset || !run) begin
            div_cnt   <= '0;
            clock_out <= 1'b0;
        end else begin
            if (hit) begin
                clock_out <= ~clock_out;
            end
            if (hit || phase_rst) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/shift_clock_scheduler.sv
// Serializes bytes MSB first, shaping the shift clock per bit value.
// Config is latched per byte; back-to-back bytes continue clock phase.
module shift_clock_scheduler
    import shift_clock_scheduler_pkg::*;
#(
    parameter int CNT_W  = 12,
    parameter int BLEN_W = 16
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic [CNT_W-1:0]  cfg_half0,
    input  logic [CNT_W-1:0]  cfg_half1,
    input  logic [BLEN_W-1:0] cfg_bit_len,
    input  logic [7:0]        data_in,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic              abort,
    output logic              clock_out,
    output logic              bit_out,
    output logic              busy,
    output logic              byte_done
);

    state_t            state;
    state_t            state_n;
    logic [7:0]        shreg;
    logic [CNT_W-1:0]  half0_q;
    logic [CNT_W-1:0]  half1_q;
    logic [CNT_W-1:0]  half_sel;
    logic [BLEN_W-1:0] bit_len_q;
    logic [BLEN_W-1:0] bit_cnt;
    logic [2:0]        bit_idx;
    logic              last_cycle;
    logic              byte_end;
    logic              accept;
    logic              run;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        last_cycle = (state == ST_SHIFT) && (bit_cnt == bit_len_q);
        byte_end   = last_cycle && (bit_idx == 3'd0);
        data_ready = !abort && ((state == ST_IDLE) || byte_end);
        accept     = data_valid && data_ready;
        half_sel   = bit_out ? half1_q : half0_q;
        state_n    = state;
        run        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort || (byte_end && !accept)) begin
                    state_n = ST_IDLE;
                end else begin
                    run = 1'b1;
                end
            end
        endcase
    end

    assign busy = (state == ST_SHIFT);

    always_ff @(posedge clock_in) begin
        if (reset) begin
            shreg     <= '0;
            half0_q   <= '0;
            half1_q   <= '0;
            bit_len_q <= '0;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            bit_out   <= 1'b0;
            byte_done <= 1'b0;
        end else if (abort) begin
            bit_cnt   <= '0;
            bit_idx   <= '0;
            bit_out   <= 1'b0;
            byte_done <= 1'b0;
        end else begin
            byte_done <= byte_end;
            if (accept) begin
                shreg     <= data_in;
                half0_q   <= cfg_half0;
                half1_q   <= cfg_half1;
                bit_len_q <= cfg_bit_len;
                bit_cnt   <= '0;
                bit_idx   <= 3'd7;
                bit_out   <= data_in[7];
            end else if (state == ST_SHIFT) begin
                if (byte_end) begin
                    bit_cnt <= '0;
                end else if (last_cycle) begin
                    bit_cnt <= '0;
                    bit_idx <= bit_idx - 3'd1;
                    bit_out <= shreg[bit_idx - 3'd1];
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    half_period_divider #(
        .CNT_W(CNT_W)
    ) u_div (
        .clock_in (clock_in),
        .reset    (reset),
        .half_lim (half_sel),
        .run      (run),
        .phase_rst(last_cycle),
        .clock_out(clock_out)
    );

endmodule

// File: tb/tb_shift_clock_scheduler.sv
// Bench for shift_clock_scheduler: directed scenarios plus random traffic,
// all checked against a timeline model of the bit/clock schedule.
module tb_shift_clock_scheduler;

    localparam int CNT_W  = 12;
    localparam int BLEN_W = 16;

    logic              clock_in = 1'b0;
    logic              reset;
    logic [CNT_W-1:0]  cfg_half0;
    logic [CNT_W-1:0]  cfg_half1;
    logic [BLEN_W-1:0] cfg_bit_len;
    logic [7:0]        data_in;
    logic              data_valid;
    logic              data_ready;
    logic              abort;
    logic              clock_out;
    logic              bit_out;
    logic              busy;
    logic              byte_done;

    always #5 clock_in = ~clock_in;

    shift_clock_scheduler #(
        .CNT_W (CNT_W),
        .BLEN_W(BLEN_W)
    ) dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .cfg_half0  (cfg_half0),
        .cfg_half1  (cfg_half1),
        .cfg_bit_len(cfg_bit_len),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .abort      (abort),
        .clock_out  (clock_out),
        .bit_out    (bit_out),
        .busy       (busy),
        .byte_done  (byte_done)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Model: a byte is a timeline of 8*(L+1) cycles; within a bit, the
    // clock has toggled floor((k+1)/(h+1)) times after cycle k.
    bit         m_busy, m_clk, m_bit, m_done, m_lvl;
    logic [7:0] m_data;
    int         m_h0, m_h1, m_L, m_t;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         done_cyc = -1;

    function automatic bit exp_ready();
        return !abort && (!m_busy || (m_t == 8 * (m_L + 1) - 1));
    endfunction

    task automatic start_byte();
        m_busy = 1'b1;
        m_data = data_in;
        m_h0   = int'(cfg_half0);
        m_h1   = int'(cfg_half1);
        m_L    = int'(cfg_bit_len);
        m_t    = 0;
        m_bit  = data_in[7];
        m_lvl  = m_clk;
        acc_cyc = cyc;
    endtask

    task automatic model_edge();
        bit rdy, acc, last, nclk;
        int bl, k, b, h;
        rdy = exp_ready();
        acc = data_valid && rdy;
        if (reset || abort) begin
            m_busy = 0; m_clk = 0; m_bit = 0;
            m_done = 0; m_t = 0; m_lvl = 0;
        end else begin
            bl = m_L + 1;
            last = m_busy && (m_t == 8 * bl - 1);
            m_done = last;
            if (m_busy) begin
                k = m_t % bl;
                b = m_t / bl;
                h = m_data[7 - b] ? m_h1 : m_h0;
                nclk = m_lvl ^ ((((k + 1) / (h + 1)) % 2) == 1);
                m_t++;
                m_clk = nclk;
                if (m_t % bl == 0) m_lvl = nclk;
                if (last) begin
                    if (acc) start_byte();
                    else begin
                        m_busy = 0; m_clk = 0; m_t = 0;
                    end
                end else begin
                    m_bit = m_data[7 - m_t / bl];
                end
            end else if (acc) begin
                start_byte();
            end
        end
    endtask

    task automatic step();
        #1;
        chk("data_ready", data_ready, exp_ready());
        @(posedge clock_in);
        cyc++;
        model_edge();
        #1;
        chk("clock_out", clock_out, m_clk);
        chk("bit_out", bit_out, m_bit);
        chk("busy", busy, m_busy);
        chk("byte_done", byte_done, m_done);
        if (byte_done) done_cyc = cyc;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cfg(input int h0, input int h1, input int bl);
        cfg_half0   = CNT_W'(h0);
        cfg_half1   = CNT_W'(h1);
        cfg_bit_len = BLEN_W'(bl);
    endtask

    task automatic send(input logic [7:0] d);
        data_in = d;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; abort = 1'b0; data_valid = 1'b0; data_in = '0;
        cfg(49, 49, 399);
        m_busy = 0; m_clk = 0; m_bit = 0; m_done = 0; m_lvl = 0;
        m_t = 0; m_h0 = 0; m_h1 = 0; m_L = 0; m_data = '0;

        run(3);
        reset = 1'b0;
        run(4);
        chk("idle_ready", data_ready, 1);

        cfg(1, 3, 15);
        send(8'hA5);
        run(140);
        chk("a5_done_at", done_cyc - acc_cyc, 128);

        cfg(1, 3, 15);
        data_in = 8'hFF;
        data_valid = 1'b1;
        run(130);
        data_in = 8'h00;
        run(140);
        data_valid = 1'b0;
        run(5);

        cfg(1, 3, 15);
        send(8'hFF);
        run(20);
        cfg(1, 7, 15);
        run(120);
        send(8'hF0);
        run(140);

        cfg(2, 5, 9);
        send(8'h3C);
        done_cyc = -1;
        run(39);
        abort = 1'b1;
        step();
        chk("abort_busy", busy, 0);
        chk("abort_clk", clock_out, 0);
        abort = 1'b0;
        run(3);
        chk("abort_no_done", done_cyc, -1);

        cfg(0, 3, 0);
        send(8'h00);
        run(12);
        chk("tiny_done_at", done_cyc - acc_cyc, 8);

        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            abort = ($urandom_range(0, 149) == 0);
            data_valid = ($urandom_range(0, 3) != 0);
            data_in = 8'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                cfg($urandom_range(0, 6), $urandom_range(0, 6),
                    $urandom_range(0, 10));
                if ($urandom_range(0, 19) == 0) cfg_half1 = '1;
            end
            step();
        end
        reset = 1'b0; abort = 1'b0; data_valid = 1'b0;
        run(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
